// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sequencing two requesters through a shared ALU datapath
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_req[1:0]                per-requester request
//   i_op0/i_op1, i_a0/i_a1,   requester op code and operands
//   i_b0/i_b1
//   i_dp_result/carry/zero    datapath R0 result and flags
//   o_gnt[1:0]                one-hot grant, held LOADA..WAIT
//   o_done[1:0]               one-cycle completion pulse
//   o_result, o_res_c/z       captured result and flags, held until next capture
//   o_busy                    high outside IDLE
//   o_ctl_*                   datapath control word
module alu_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req,
  input  logic [3:0]  i_op0,
  input  logic [3:0]  i_op1,
  input  logic [11:0] i_a0,
  input  logic [11:0] i_a1,
  input  logic [11:0] i_b0,
  input  logic [11:0] i_b1,
  input  logic [11:0] i_dp_result,
  input  logic        i_dp_carry,
  input  logic        i_dp_zero,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_done,
  output logic [11:0] o_result,
  output logic        o_res_c,
  output logic        o_res_z,
  output logic        o_busy,
  output logic        o_ctl_ot,
  output logic [3:0]  o_ctl_sbs,
  output logic [3:0]  o_ctl_alu,
  output logic [2:0]  o_ctl_shft,
  output logic [3:0]  o_ctl_dest,
  output logic [11:0] o_ctl_const
);
  localparam logic       O_NIL         = 1'b0;
  localparam logic       O_WR          = 1'b1;
  localparam logic [3:0] SBUS_IN       = 4'd0;
  localparam logic [3:0] SBUS_R0       = 4'd1;
  localparam logic [3:0] SBUS_ADDCONST = 4'd8;
  localparam logic [3:0] ALU_PASS      = 4'd0;
  localparam logic [2:0] SHFT_NIL      = 3'd0;
  localparam logic [3:0] DST_NIL       = 4'd0;
  localparam logic [3:0] DST_ACC       = 4'd1;
  localparam logic [3:0] DST_R0        = 4'd2;
  typedef enum logic [2:0] {S_IDLE, S_LOADA, S_EXEC, S_WAIT, S_DONE} state_t;
  state_t      r_state;
  logic        r_win;
  logic        r_last;
  logic [3:0]  r_op;
  logic [11:0] r_b;
  logic        w_win;
  // A lone requester wins outright; on a tie the one not served last wins.
  assign w_win = (i_req == 2'b10) | ((i_req == 2'b11) & ~r_last);
  // Every output is a register; the control word for a state is loaded on the
  // edge that enters that state, so it is visible for exactly that cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_win       <= 1'b0;
      r_last      <= 1'b1;
      r_op        <= 4'd0;
      r_b         <= 12'd0;
      o_gnt       <= 2'b00;
      o_done      <= 2'b00;
      o_result    <= 12'd0;
      o_res_c     <= 1'b0;
      o_res_z     <= 1'b0;
      o_busy      <= 1'b0;
      o_ctl_ot    <= O_NIL;
      o_ctl_sbs   <= SBUS_IN;
      o_ctl_alu   <= ALU_PASS;
      o_ctl_shft  <= SHFT_NIL;
      o_ctl_dest  <= DST_NIL;
      o_ctl_const <= 12'd0;
    end else begin
      o_done      <= 2'b00;
      o_ctl_ot    <= O_NIL;
      o_ctl_sbs   <= SBUS_IN;
      o_ctl_alu   <= ALU_PASS;
      o_ctl_shft  <= SHFT_NIL;
      o_ctl_dest  <= DST_NIL;
      o_ctl_const <= 12'd0;
      case (r_state)
        S_IDLE: if (|i_req) begin
          r_state     <= S_LOADA;
          r_win       <= w_win;
          r_last      <= w_win;
          r_op        <= w_win ? i_op1 : i_op0;
          r_b         <= w_win ? i_b1 : i_b0;
          o_gnt       <= w_win ? 2'b10 : 2'b01;
          o_busy      <= 1'b1;
          o_ctl_sbs   <= SBUS_ADDCONST;
          o_ctl_dest  <= DST_ACC;
          o_ctl_const <= w_win ? i_a1 : i_a0;
        end
        S_LOADA: begin
          r_state     <= S_EXEC;
          o_ctl_sbs   <= SBUS_ADDCONST;
          o_ctl_alu   <= r_op;
          o_ctl_dest  <= DST_R0;
          o_ctl_const <= r_b;
        end
        S_EXEC: r_state <= S_WAIT;
        // R0 is settled during WAIT, so it is captured on the edge into DONE
        // and presented alongside the done pulse.
        S_WAIT: begin
          r_state   <= S_DONE;
          o_result  <= i_dp_result;
          o_res_c   <= i_dp_carry;
          o_res_z   <= i_dp_zero;
          o_done    <= r_win ? 2'b10 : 2'b01;
          o_gnt     <= 2'b00;
          o_ctl_ot  <= O_WR;
          o_ctl_sbs <= SBUS_R0;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, as listed in REQ-002 and REQ-003.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 req  input  2  per-requester request; bit i = requester i.
REQ-005 op0, op1  input  4 each  ALU operation code (globals ALU_* encoding) of requester 0/1.
REQ-006 a0, a1  input  12 each  first operand of requester 0/1.
REQ-007 b0, b1  input  12 each  second operand of requester 0/1.
REQ-008 dp_result  input  12  datapath R0 result.
REQ-009 dp_carry  input  1  datapath carry flag.
REQ-010 dp_zero  input  1  datapath zero flag.
REQ-011 gnt  output  2  one-hot grant, held for the whole transaction.
REQ-012 done  output  2  one-cycle completion pulse to the granted requester.
REQ-013 result  output  12  captured result; valid while done is nonzero and held until next capture.
REQ-014 res_c, res_z  output  1 each  captured carry/zero flags, same timing as result.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 ctl_ot  output  1; ctl_sbs  output  4; ctl_alu  output  4; ctl_shft  output  3; ctl_dest  output  4; ctl_const  output  12  datapath control word (globals encodings).

Function
REQ-017 FSM states SHALL be IDLE, LOADA, EXEC, WAIT, DONE; all outputs registered.
REQ-018 IDLE: if req != 0, select winner, latch its op/a/b, set gnt to winner, go LOADA next cycle; else stay.
REQ-019 Arbitration SHALL be round-robin: single requester wins; both requesting -> requester other than last_served wins; last_served updates on entering LOADA.
REQ-020 LOADA (1 cycle): ctl_sbs=SBUS_ADDCONST, ctl_alu=ALU_PASS, ctl_dest=DST_ACC, ctl_const=latched a; go EXEC.
REQ-021 EXEC (1 cycle): ctl_sbs=SBUS_ADDCONST, ctl_alu=latched op, ctl_dest=DST_R0, ctl_const=latched b; go WAIT.
REQ-022 WAIT (1 cycle): control word NIL (O_NIL, SBUS_IN, ALU_PASS, SHFT_NIL, DST_NIL, const 0); go DONE.
REQ-023 DONE (1 cycle): capture dp_result/dp_carry/dp_zero into result/res_c/res_z, pulse done[winner], ctl_ot=O_WR, ctl_sbs=SBUS_R0, ctl_dest=DST_NIL; clear gnt; go IDLE.
REQ-024 ctl_shft SHALL be SHFT_NIL in every state.
REQ-025 Latency: req sampled in IDLE at edge N -> gnt at N+1, done pulse at N+4; back-to-back grants SHALL have one IDLE cycle between them (5-cycle throughput).
REQ-026 Operands and op SHALL be latched once at grant; requester changes after grant SHALL NOT affect the transaction.
REQ-027 Requester SHALL hold req until its done; req deasserted mid-transaction SHALL NOT abort it; done is still pulsed.
REQ-028 Op code SHALL be passed unchecked; dp_result is taken as 12 bits, no width extension.
REQ-029 done SHALL never be nonzero for more than one consecutive cycle, and gnt and done SHALL never both be nonzero for different requesters.

Reset
REQ-030 rst_n low at any edge, including mid-transaction, SHALL force IDLE next cycle: gnt=0, done=0, busy=0, result=0, res_c=0, res_z=0, control word NIL, last_served=1 (requester 0 wins first tie); no done pulse for the aborted transaction.

Verification
REQ-031 Single request: req=01, op0=ALU_ADD, a0=5, b0=3, dp_result=8 in DONE -> gnt=01 at N+1..N+3, LOADA const=5, EXEC const=3 ALU_ADD, done=01 and result=8 at N+4.
REQ-032 Tie after reset: req=11 held -> grant order 0,1,0,1; each done pulses once; one IDLE cycle between grants.
REQ-033 Operand change: a0 changed from 5 to 9 at N+2 -> ctl_const stays 5 in LOADA window as latched, EXEC const=b0 as latched.
REQ-034 Request drop: req=01 deasserted at N+2 -> transaction completes, done=01 at N+4, then IDLE.
REQ-035 Reset mid-op: rst_n low in EXEC -> next cycle all outputs zero/NIL, no done; req=11 after release -> requester 0 granted.
REQ-036 Flags: dp_carry=1, dp_zero=1, dp_result=0 in DONE -> res_c=1, res_z=1, result=0 held until next capture.
